// File: rtl/lshift_ctrl.sv
// Load/shift sequencer for a left-shift register: accepts a seed+count job, loads, shifts, captures.
// Optional abort input enabled by defining LSHIFT_CTRL_ABORT_EN.
module lshift_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_val,
    input  logic [CNT_W-1:0] req_count,
    output logic [WIDTH-1:0] load_val,
    output logic             load_en,
    output logic             shift_en,
    input  logic [WIDTH-1:0] op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef LSHIFT_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        CAPT  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] load_val_q;
    logic [WIDTH-1:0] result_q;
    logic             load_en_q;
    logic             shift_en_q;
    logic             done_q;
    logic             abort_w;

`ifdef LSHIFT_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Strobes are registered alongside the state they belong to, so they
    // line up exactly with the LOAD / SHIFT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            load_val_q <= '0;
            result_q   <= '0;
            load_en_q  <= 1'b0;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            load_en_q  <= 1'b0;
            shift_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        load_val_q <= req_val;
                        cnt_q      <= req_count;
                        load_en_q  <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_w) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= CAPT;
                    end else begin
                        shift_en_q <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort_w) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= CAPT;
                        end else begin
                            shift_en_q <= 1'b1;
                        end
                    end
                end
                CAPT: begin
                    result_q <= op;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign load_val  = load_val_q;
    assign load_en   = load_en_q;
    assign shift_en  = shift_en_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_lshift_ctrl.sv
// Self-checking bench for lshift_ctrl against a zero-fill left-shift register model and job timeline.
module tb_lshift_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_val;
    logic [CNT_W-1:0] req_count;
    logic [WIDTH-1:0] load_val;
    logic             load_en;
    logic             shift_en;
    logic [WIDTH-1:0] op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef LSHIFT_CTRL_ABORT_EN
    logic             abort;
`endif

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_res = '0;
    logic [WIDTH-1:0] sr = '0;

    always #5 clk = ~clk;

    lshift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val   (req_val),
        .req_count (req_count),
        .load_val  (load_val),
        .load_en   (load_en),
        .shift_en  (shift_en),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef LSHIFT_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Zero-fill left shift register driven by the controller
    always @(posedge clk) begin
        if (load_en)       sr <= load_val;
        else if (shift_en) sr <= sr << 1;
    end
    assign op = sr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({req_ready, busy, load_en, shift_en, done});
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_ctl", ctl_vec(), 32'b10000);
            chk("idle_result", 32'(result), 32'(exp_res));
        end
    endtask

    // Timeline from the accepting edge: cycle 0 LOAD, 1..cnt SHIFT,
    // cnt+1 CAPT, cnt+2 first IDLE cycle with done high.
    task automatic job(input logic [WIDTH-1:0] seed, input int cnt, input int last_c);
        logic [WIDTH-1:0] new_res;
        logic [4:0]       e;
        new_res   = seed << cnt;
        req_valid = 1'b1;
        req_val   = seed;
        req_count = CNT_W'(cnt);
        chk("ready_at_req", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_val   = WIDTH'($urandom);
        req_count = CNT_W'($urandom);
        for (int c = 0; c <= last_c; c++) begin
            if (c > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            e = {c == cnt + 2, c != cnt + 2, c == 0, (c >= 1) && (c <= cnt), c == cnt + 2};
            chk($sformatf("ctl_c%0d_n%0d", c, cnt), ctl_vec(), 32'(e));
            if (c == 0 || c == last_c) chk("load_val", 32'(load_val), 32'(seed));
            if (c == cnt + 2) exp_res = new_res;
            chk($sformatf("result_c%0d", c), 32'(result), 32'(exp_res));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] s;
        int               n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_val   = '0;
        req_count = '0;
`ifdef LSHIFT_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ctl", ctl_vec(), 32'b10000);
        chk("reset_load_val", 32'(load_val), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        idle(1);

        // Basic job followed back-to-back by a second one in the done cycle
        job(8'h01, 3, 5);
        job(8'h03, 2, 4);
        idle(2);

        job(8'hA5, 0, 2);
        idle(1);

        // Reset after four shifts drops the job
        job(8'h01, 10, 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_res = '0;
        chk("midrst_ctl", ctl_vec(), 32'b10000);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_load_val", 32'(load_val), 32'd0);
        idle(12);

        job(8'hFF, 31, 33);
        job(8'hFF, 7, 9);
        idle(1);

`ifdef LSHIFT_CTRL_ABORT_EN
        job(8'h5A, 1, 3);
        job(8'h01, 6, 2);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_shift_ctl", ctl_vec(), 32'b10000);
        chk("abort_shift_result", 32'(result), 32'(exp_res));
        idle(8);
        job(8'h11, 4, 0);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_load_ctl", ctl_vec(), 32'b10000);
        idle(2);
        abort = 1'b0;
        job(8'h07, 1, 3);
        idle(1);
`endif

        for (int j = 0; j < 20; j++) begin
            s = WIDTH'($urandom);
            n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
            job(s, n, n + 2);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
